// File: rtl/rvfi_csr_check_pkg.sv
// Shared types for the RVFI CSR shadow checker: FSM states, error causes,
// and the channel index used to report where the first error happened.
package rvfi_csr_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAIL  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_DATA  = 2'd1,
        ERR_ORDER = 2'd2,
        ERR_WTRAP = 2'd3
    } err_code_t;

    typedef logic [1:0] chan_t;

endpackage

// File: rtl/rvfi_csr_shadow_check_if.sv
// RVFI retirement bundle restricted to the fields the CSR shadow checker observes.
interface rvfi_csr_shadow_check_if #(
    parameter int XLEN   = 32,
    parameter int NRET   = 1,
    parameter int ORDERW = 64
);
    logic [NRET-1:0]        rvfi_valid;
    logic [NRET*ORDERW-1:0] rvfi_order;
    logic [NRET-1:0]        rvfi_trap;
    logic [NRET*XLEN-1:0]   rvfi_csr_rmask;
    logic [NRET*XLEN-1:0]   rvfi_csr_wmask;
    logic [NRET*XLEN-1:0]   rvfi_csr_rdata;
    logic [NRET*XLEN-1:0]   rvfi_csr_wdata;

    modport master (
        output rvfi_valid, rvfi_order, rvfi_trap,
        output rvfi_csr_rmask, rvfi_csr_wmask, rvfi_csr_rdata, rvfi_csr_wdata
    );

    modport slave (
        input rvfi_valid, rvfi_order, rvfi_trap,
        input rvfi_csr_rmask, rvfi_csr_wmask, rvfi_csr_rdata, rvfi_csr_wdata
    );
endinterface

// File: rtl/rvfi_csr_shadow_lane.sv
// One retirement channel: order/trap/data checks against the incoming shadow,
// then the shadow/known/expected_order values handed to the next channel.
module rvfi_csr_shadow_lane
    import rvfi_csr_check_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ORDERW = 64
) (
    input  logic              valid,
    input  logic              trap,
    input  logic              gap,
    input  logic              prev_seed,
    input  logic [ORDERW-1:0] order,
    input  logic [ORDERW-1:0] prev_exp,
    input  logic [XLEN-1:0]   rmask,
    input  logic [XLEN-1:0]   wmask,
    input  logic [XLEN-1:0]   rdata,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   prev_shadow,
    input  logic [XLEN-1:0]   prev_known,
    output logic [XLEN-1:0]   next_shadow,
    output logic [XLEN-1:0]   next_known,
    output logic [ORDERW-1:0] next_exp,
    output logic              next_seed,
    output err_code_t         code
);
    logic              active;
    logic [ORDERW-1:0] eff_exp;
    logic              order_err;
    logic              trap_err;
    logic              data_err;

    always_comb begin
        active    = valid && !trap;
        // The first valid channel after reset defines where the order sequence starts.
        eff_exp   = prev_seed ? order : prev_exp;
        order_err = valid && (gap || (order != eff_exp));
        trap_err  = valid && trap && (|wmask);
        data_err  = active && (|(rmask & prev_known & (rdata ^ prev_shadow)));

        code = ERR_NONE;
        if (order_err)     code = ERR_ORDER;
        else if (trap_err) code = ERR_WTRAP;
        else if (data_err) code = ERR_DATA;

        next_shadow = prev_shadow;
        next_known  = prev_known;
        if (active) begin
            next_shadow = (wmask & wdata) | (rmask & ~wmask & rdata) | (~(rmask | wmask) & prev_shadow);
            next_known  = prev_known | rmask | wmask;
        end

        next_exp  = valid ? (eff_exp + ORDERW'(1)) : prev_exp;
        next_seed = prev_seed && !valid;
    end
endmodule

// File: rtl/rvfi_csr_shadow_check.sv
// Tracks one CSR through RVFI retirements and latches the first inconsistency
// (data mismatch, order gap, write-on-trap) seen across the retirement channels.
module rvfi_csr_shadow_check
    import rvfi_csr_check_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NRET   = 1,
    parameter int ORDERW = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     check,
    rvfi_csr_shadow_check_if.slave   rv,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic [1:0]               err_chan,
    output logic [31:0]              retired
);
    state_t            state, state_n;
    logic [XLEN-1:0]   shadow, shadow_n;
    logic [XLEN-1:0]   known, known_n;
    logic [ORDERW-1:0] expected_order, exp_n;
    logic              err_q, err_n;
    err_code_t         code_q, code_n;
    chan_t             chan_q, chan_n;
    logic [31:0]       retired_q, retired_n;

    logic [XLEN-1:0]   shadow_c [NRET+1];
    logic [XLEN-1:0]   known_c  [NRET+1];
    logic [ORDERW-1:0] exp_c    [NRET+1];
    logic              seed_c   [NRET+1];
    err_code_t         lane_code [NRET];
    logic [NRET-1:0]   gap;

    logic              hole;
    logic [2:0]        cnt;
    logic [32:0]       sum;
    logic              hit;
    err_code_t         hit_code;
    chan_t             hit_chan;

    assign shadow_c[0] = shadow;
    assign known_c[0]  = known;
    assign exp_c[0]    = expected_order;
    assign seed_c[0]   = (state == IDLE);

    for (genvar i = 0; i < NRET; i++) begin : g_lane
        rvfi_csr_shadow_lane #(.XLEN(XLEN), .ORDERW(ORDERW)) u_lane (
            .valid       (rv.rvfi_valid[i]),
            .trap        (rv.rvfi_trap[i]),
            .gap         (gap[i]),
            .prev_seed   (seed_c[i]),
            .order       (rv.rvfi_order[i*ORDERW +: ORDERW]),
            .prev_exp    (exp_c[i]),
            .rmask       (rv.rvfi_csr_rmask[i*XLEN +: XLEN]),
            .wmask       (rv.rvfi_csr_wmask[i*XLEN +: XLEN]),
            .rdata       (rv.rvfi_csr_rdata[i*XLEN +: XLEN]),
            .wdata       (rv.rvfi_csr_wdata[i*XLEN +: XLEN]),
            .prev_shadow (shadow_c[i]),
            .prev_known  (known_c[i]),
            .next_shadow (shadow_c[i+1]),
            .next_known  (known_c[i+1]),
            .next_exp    (exp_c[i+1]),
            .next_seed   (seed_c[i+1]),
            .code        (lane_code[i])
        );
    end

    always_comb begin
        hole = 1'b0;
        gap  = '0;
        cnt  = '0;
        for (int i = 0; i < NRET; i++) begin
            gap[i] = rv.rvfi_valid[i] && hole;
            hole   = hole || !rv.rvfi_valid[i];
            cnt    = cnt + 3'(rv.rvfi_valid[i]);
        end
        sum       = {1'b0, retired_q} + 33'(cnt);
        retired_n = sum[32] ? 32'hFFFF_FFFF : sum[31:0];

        // Scan from the top down so the lowest erroring channel is what remains.
        hit      = 1'b0;
        hit_code = ERR_NONE;
        hit_chan = '0;
        for (int i = NRET - 1; i >= 0; i--) begin
            if (lane_code[i] != ERR_NONE) begin
                hit      = 1'b1;
                hit_code = lane_code[i];
                hit_chan = chan_t'(i);
            end
        end

        state_n  = state;
        shadow_n = shadow;
        known_n  = known;
        exp_n    = expected_order;
        err_n    = err_q;
        code_n   = code_q;
        chan_n   = chan_q;

        case (state)
            IDLE, TRACK: begin
                if (hit) begin
                    state_n = FAIL;
                    err_n   = 1'b1;
                    code_n  = hit_code;
                    chan_n  = hit_chan;
                end else begin
                    shadow_n = shadow_c[NRET];
                    known_n  = known_c[NRET];
                    exp_n    = exp_c[NRET];
                    if (!seed_c[NRET]) state_n = TRACK;
                end
            end
            FAIL: ;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            shadow         <= '0;
            known          <= '0;
            expected_order <= '0;
            err_q          <= 1'b0;
            code_q         <= ERR_NONE;
            chan_q         <= '0;
            retired_q      <= '0;
        end else begin
            state          <= state_n;
            shadow         <= shadow_n;
            known          <= known_n;
            expected_order <= exp_n;
            err_q          <= err_n;
            code_q         <= code_n;
            chan_q         <= chan_n;
            retired_q      <= retired_n;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && check) assert (!err_q);
    end

    assign err      = err_q;
    assign err_code = code_q;
    assign err_chan = chan_q;
    assign retired  = retired_q;
endmodule
